bpi_cmd_sequencer: RTL and testbench
====================================

# bpi_cmd_sequencer

Command sequencer that drives the BPI flash bus interface (`bpi_interface`) from single high-level requests. It expands each request into the flash's multi-cycle command/data bus sequence and handshakes every bus cycle via EXECUTE/BUSY. After program and erase it polls the flash status register until ready, then reports completion and the error flags. It sits between the VME-side BPI control logic and `bpi_interface`, and owns BPI_ACTIVE.

## Interface
- `POLL_GAP`, default 16: idle cycles between successive status polls (1..255).
- `TIMEOUT_CYCLES`, default 2^24: poll watchdog limit in CLK cycles; used only with the timeout macro.
- `CLK` in 1: 40 MHz clock.
- `RST_B` in 1: reset, synchronous, active-low.
- `START` in 1: request strobe; sampled only in IDLE.
- `CMD` in 3: 0 nop, 1 read word, 2 read status, 3 program word, 4 block erase, 5 block unlock, 6 clear status, 7 nop.
- `ADDR_IN` in 23: word address (read/program) or block address (erase/unlock).
- `WDATA` in 16: program data.
- `SEQ_BUSY` out 1: request in progress.
- `DONE` out 1: one-cycle completion pulse.
- `ERR` out 1: error flag, valid with DONE, held until next START.
- `STATUS` out 8: last status byte read, held.
- `RD_DATA` out 16: read result, held.
- `RD_VALID` out 1: one-cycle pulse when RD_DATA updates.
- `BPI_OP` out 2: 01 write, 10 read, 00 standby.
- `BPI_ADDR` out 23: bus address.
- `BPI_CMD_DATA` out 16: bus command or data.
- `BPI_EXECUTE` out 1: one-cycle bus-cycle launch pulse.
- `BPI_ACTIVE` out 1: high while a request is in progress.
- `BPI_BUSY` in 1: bus cycle in progress.
- `BPI_LOAD_DATA` in 1: read-data capture strobe.
- `BPI_DATA_IN` in 16: data read from flash.

## Operation
- **Request acceptance.** START with CMD 0/7 in IDLE produces DONE on the next cycle with ERR=0 and no bus activity.
- **Bus-cycle lists.** Each bus cycle is {OP, ADDR, DATA}. Read cycles have DATA=0.
  - read word: W(ADDR,FF); R(ADDR).
  - read status: W(ADDR,70); R(ADDR) → STATUS.
  - program: W(ADDR,40); W(ADDR,WDATA); then poll.
  - erase: W(ADDR,20); W(ADDR,D0); then poll.
  - unlock: W(ADDR,60); W(ADDR,D0). No poll.
  - clear status: W(ADDR,50).
- **States.**
  - IDLE → ISSUE on accepted START. START latches CMD, ADDR_IN and WDATA, clears ERR, and sets SEQ_BUSY and BPI_ACTIVE.
  - ISSUE: drive OP/ADDR/DATA and pulse BPI_EXECUTE for 1 cycle → WAIT_ACK.
  - WAIT_ACK: wait for BPI_BUSY=1 → WAIT_END.
  - WAIT_END: wait for BPI_BUSY=0. On a read cycle, capture BPI_DATA_IN on the cycle where BPI_LOAD_DATA=1. Then:
    - if more cycles remain in the list → ISSUE;
    - else if the request needs polling → GAP;
    - else → FIN.
  - GAP: count POLL_GAP cycles → POLL_R.
  - POLL_R: issue R(ADDR) through ISSUE/WAIT_ACK/WAIT_END. STATUS ← captured[7:0]. If SR7=1 → FIN, else → GAP.
  - FIN: pulse DONE. Pulse RD_VALID if the request was a read word. Deassert SEQ_BUSY and BPI_ACTIVE → IDLE.
- **Error.** ERR = SR5|SR4|SR3|SR1 of the final STATUS for program/erase/read-status requests. ERR=0 for the other requests.
- **Signal holding.** BPI_OP, BPI_ADDR and BPI_CMD_DATA are held stable from ISSUE until the next ISSUE. BPI_OP returns to 00 in IDLE.
- **Lost LOAD.** If no BPI_LOAD_DATA arrives on a read cycle, RD_DATA/STATUS keep their previous value and ERR is set at FIN.

## Timing
- **Reset values.** RST_B=0 on a rising edge forces IDLE from any state, including mid-sequence. All outputs go to 0 except BPI_OP=00; RD_DATA=0, STATUS=0.
- **First bus cycle.** START accepted at edge N → BPI_EXECUTE high for cycle N+1 only.
- **Back-to-back cycles.** The next ISSUE follows one cycle after BPI_BUSY falls.
- **DONE.** DONE is asserted the cycle after the last BPI_BUSY fall (or the last GAP/poll resolution). SEQ_BUSY falls in that same cycle. START in that same DONE cycle is ignored; the earliest accepted START is the cycle after DONE.
- **Busy requests.** START while SEQ_BUSY=1 is ignored, with no queueing.
- **Stuck bus.** BPI_BUSY already high in WAIT_ACK is accepted immediately. BPI_BUSY stuck low in WAIT_ACK stalls the sequencer unless the timeout is compiled in.
- **Timeout counter.** Counter width is ceil(log2(TIMEOUT_CYCLES+1)), saturating. It counts from the first GAP entry.

## Configuration
- `BPI_SEQ_TIMEOUT_EN` defined:
  - a watchdog counts every cycle outside IDLE/FIN;
  - reaching TIMEOUT_CYCLES → FIN with ERR=1 and STATUS unchanged;
  - BPI_OP is forced to 00 at that transition.
- Not defined:
  - no counter logic;
  - polling continues indefinitely;
  - TIMEOUT_CYCLES is ignored.

## Test plan
- Read word, ADDR_IN=0x12345, flash model returns 0xBEEF → bus sees W(0x12345,0x00FF), R(0x12345). Then RD_VALID + DONE with RD_DATA=0xBEEF, ERR=0, EXECUTE pulses exactly 2.
- Program 0x0A5A5 at 0x00100, model reports SR=0x00 for 3 polls then 0x80 → W 0x40, W 0xA5A5, 4 reads spaced ≥POLL_GAP cycles. DONE with STATUS=0x80, ERR=0.
- Erase, model returns SR=0xA0 → DONE with STATUS=0xA0, ERR=1. A START issued mid-sequence produces no extra bus cycles.
- RST_B low for 1 cycle during the second poll GAP → next cycle has all outputs at reset values. A new read-status request then completes normally with STATUS=model value.
- With `BPI_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=200, SR stuck at 0x00 → DONE with ERR=1 within 200 cycles of the first GAP entry, then BPI_OP=00.
- CMD=0 START → DONE the next cycle, ERR=0, zero EXECUTE pulses. Unlock → exactly W 0x60, W 0xD0, no reads.

Source files
------------

// File: rtl/bpi_cmd_sequencer.sv
// rtl/bpi_cmd_sequencer.sv - BPI flash command sequencer: expands requests into bus cycles and polls status
//
// Purpose : Accepts one high-level flash request (read word, read status, program,
//           erase, unlock, clear status), issues the matching list of BPI bus
//           cycles through the EXECUTE/BUSY handshake, polls the status register
//           after program/erase until SR7 is set, then pulses DONE with ERR.
// Option  : define BPI_SEQ_TIMEOUT_EN to compile in a watchdog of TIMEOUT_CYCLES
//           that forces completion with ERR=1 when the flash never reports ready.
// Ports   :
//   i_clk, i_rst_b                  clock, synchronous active-low reset
//   i_start, i_cmd, i_addr_in,
//   i_wdata                         request strobe, opcode, address, program data
//   o_seq_busy, o_done, o_err       request in progress, completion pulse, error flag
//   o_status, o_rd_data, o_rd_valid last status byte, last read word, read-word pulse
//   o_bpi_op, o_bpi_addr,
//   o_bpi_cmd_data, o_bpi_execute,
//   o_bpi_active                    bus-cycle request towards bpi_interface
//   i_bpi_busy, i_bpi_load_data,
//   i_bpi_data_in                   bus-cycle status and read data from bpi_interface
module bpi_cmd_sequencer #(
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_start,
  input  logic [2:0]  i_cmd,
  input  logic [22:0] i_addr_in,
  input  logic [15:0] i_wdata,
  output logic        o_seq_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [7:0]  o_status,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  output logic [1:0]  o_bpi_op,
  output logic [22:0] o_bpi_addr,
  output logic [15:0] o_bpi_cmd_data,
  output logic        o_bpi_execute,
  output logic        o_bpi_active,
  input  logic        i_bpi_busy,
  input  logic        i_bpi_load_data,
  input  logic [15:0] i_bpi_data_in
);

  localparam logic [2:0] CMD_RD_WORD  = 3'd1;
  localparam logic [2:0] CMD_RD_STAT  = 3'd2;
  localparam logic [2:0] CMD_PROG     = 3'd3;
  localparam logic [2:0] CMD_ERASE    = 3'd4;
  localparam logic [2:0] CMD_UNLOCK   = 3'd5;
  localparam logic [2:0] CMD_CLR_STAT = 3'd6;

  localparam logic [1:0] OP_IDLE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  if (POLL_GAP < 1 || POLL_GAP > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bpi_cmd_sequencer: POLL_GAP must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  // Status polls reuse ISSUE/WAIT_ACK/WAIT_END with r_polling set, so the
  // poll-read step needs no state of its own.
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_END, S_GAP, S_FIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cmd;
  logic [22:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_idx;        // index into the command's two-entry bus-cycle list
  logic        r_polling;    // current bus cycle is a status poll
  logic [7:0]  r_gap;
  logic        r_got_load;
  logic        r_err;
  logic [7:0]  r_status;
  logic [15:0] r_rd_data;

  logic        w_in_nop;
  logic        w_is_read;
  logic        w_last;
  logic        w_needs_poll;
  logic        w_load;
  logic        w_lost;
  logic [7:0]  w_sr;
  logic        w_sr_err;
  logic        w_err;
  logic        w_timeout;
  logic        w_tmo_hold;
  logic [1:0]  w_op;
  logic [15:0] w_bus_data;

  assign w_in_nop     = (i_cmd == 3'd0) || (i_cmd == 3'd7);
  assign w_is_read    = r_polling || (((r_cmd == CMD_RD_WORD) || (r_cmd == CMD_RD_STAT)) && r_idx);
  assign w_last       = r_polling || (r_cmd == CMD_CLR_STAT) || r_idx;
  assign w_needs_poll = (r_cmd == CMD_PROG) || (r_cmd == CMD_ERASE);
  assign w_load       = (r_state == S_WAIT_END) && w_is_read && i_bpi_load_data;
  // A read cycle that ends without any load strobe keeps the old data and flags ERR.
  assign w_lost       = (r_state == S_WAIT_END) && !i_bpi_busy && w_is_read && !r_got_load && !w_load;
  // Bypass so the poll decision and ERR see a status byte captured on the final cycle.
  assign w_sr         = w_load ? i_bpi_data_in[7:0] : r_status;
  assign w_sr_err     = ((r_cmd == CMD_RD_STAT) || w_needs_poll) && (w_sr[5] | w_sr[4] | w_sr[3] | w_sr[1]);
  assign w_err        = (r_state != S_IDLE) && (w_timeout || w_lost || w_sr_err);

`ifdef BPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_wd;
  logic          r_gap_seen;
  logic          r_tmo;

  // Watchdog runs for the whole request and restarts once at the first GAP entry,
  // so a stuck bus is rescued and the poll budget is measured from polling start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_wd       <= '0;
      r_gap_seen <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_wd       <= '0;
        r_gap_seen <= 1'b0;
        r_tmo      <= 1'b0;
      end else if (r_state == S_FIN) begin
        r_wd <= '0;
      end else if (!r_gap_seen && (w_next == S_GAP)) begin
        r_wd       <= '0;
        r_gap_seen <= 1'b1;
      end else if (r_wd != TW'(TIMEOUT_CYCLES)) begin
        r_wd <= r_wd + TW'(1);
      end
      if (w_timeout) r_tmo <= 1'b1;
    end
  end

  assign w_timeout  = (r_state != S_IDLE) && (r_state != S_FIN) && (r_wd >= TW'(TIMEOUT_CYCLES - 1));
  assign w_tmo_hold = r_tmo;
`else
  assign w_timeout  = 1'b0;
  assign w_tmo_hold = 1'b0;
`endif

  // Bus-cycle list lookup; the result only changes at ISSUE because r_cmd,
  // r_idx and r_polling are only updated on the edge into ISSUE.
  always_comb begin
    w_op       = OP_IDLE;
    w_bus_data = 16'h0000;
    if (r_polling) begin
      w_op = OP_READ;
    end else begin
      case (r_cmd)
        CMD_RD_WORD: begin
          w_op       = r_idx ? OP_READ : OP_WRITE;
          w_bus_data = r_idx ? 16'h0000 : 16'h00FF;
        end
        CMD_RD_STAT: begin
          w_op       = r_idx ? OP_READ : OP_WRITE;
          w_bus_data = r_idx ? 16'h0000 : 16'h0070;
        end
        CMD_PROG: begin
          w_op       = OP_WRITE;
          w_bus_data = r_idx ? r_wdata : 16'h0040;
        end
        CMD_ERASE: begin
          w_op       = OP_WRITE;
          w_bus_data = r_idx ? 16'h00D0 : 16'h0020;
        end
        CMD_UNLOCK: begin
          w_op       = OP_WRITE;
          w_bus_data = r_idx ? 16'h00D0 : 16'h0060;
        end
        CMD_CLR_STAT: begin
          w_op       = OP_WRITE;
          w_bus_data = 16'h0050;
        end
        default: begin
          w_op       = OP_IDLE;
          w_bus_data = 16'h0000;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next = w_in_nop ? S_FIN : S_ISSUE;
      S_ISSUE:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (i_bpi_busy) w_next = S_WAIT_END;
      S_WAIT_END: begin
        if (!i_bpi_busy) begin
          if (w_lost)            w_next = S_FIN;
          else if (!w_last)      w_next = S_ISSUE;
          else if (r_polling)    w_next = w_sr[7] ? S_FIN : S_GAP;
          else if (w_needs_poll) w_next = S_GAP;
          else                   w_next = S_FIN;
        end
      end
      S_GAP:      if (r_gap == 8'd0) w_next = S_ISSUE;
      S_FIN:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_FIN;
  end

  always_comb begin
    o_bpi_execute = (r_state == S_ISSUE);
    o_done        = (r_state == S_FIN);
    o_rd_valid    = (r_state == S_FIN) && (r_cmd == CMD_RD_WORD);
    o_seq_busy    = (r_state != S_IDLE) && (r_state != S_FIN);
    o_bpi_active  = (r_state != S_IDLE) && (r_state != S_FIN);
    o_bpi_op      = ((r_state == S_IDLE) || w_tmo_hold) ? OP_IDLE : w_op;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_cmd      <= 3'd0;
      r_addr     <= 23'd0;
      r_wdata    <= 16'h0000;
      r_idx      <= 1'b0;
      r_polling  <= 1'b0;
      r_gap      <= 8'd0;
      r_got_load <= 1'b0;
      r_err      <= 1'b0;
      r_status   <= 8'h00;
      r_rd_data  <= 16'h0000;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_cmd     <= i_cmd;
        r_addr    <= i_addr_in;
        r_wdata   <= i_wdata;
        r_idx     <= 1'b0;
        r_polling <= 1'b0;
        r_err     <= 1'b0;
      end
      if (r_state == S_ISSUE) r_got_load <= 1'b0;
      if (w_load) begin
        r_got_load <= 1'b1;
        if (r_polling || (r_cmd == CMD_RD_STAT)) r_status  <= i_bpi_data_in[7:0];
        else                                     r_rd_data <= i_bpi_data_in;
      end
      if ((r_state == S_WAIT_END) && (w_next == S_ISSUE)) r_idx <= 1'b1;
      if (r_state == S_GAP) begin
        if (w_next == S_ISSUE) r_polling <= 1'b1;
        else                   r_gap     <= r_gap - 8'd1;
      end
      if ((r_state != S_GAP) && (w_next == S_GAP)) r_gap <= 8'(POLL_GAP - 1);
      if ((r_state != S_FIN) && (w_next == S_FIN)) r_err <= w_err;
    end
  end

  assign o_err          = r_err;
  assign o_status       = r_status;
  assign o_rd_data      = r_rd_data;
  assign o_bpi_addr     = r_addr;
  assign o_bpi_cmd_data = w_bus_data;

endmodule

// File: tb/tb_bpi_cmd_sequencer.sv
// tb/tb_bpi_cmd_sequencer.sv - self-checking bench for bpi_cmd_sequencer with a BPI flash model
module tb_bpi_cmd_sequencer;

  localparam int POLL_GAP = 4;
  localparam int TMO      = 200;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic [22:0] addr_in = 23'd0;
  logic [15:0] wdata = 16'h0;
  logic        seq_busy, done, err, rd_valid, bpi_execute, bpi_active;
  logic [7:0]  status;
  logic [15:0] rd_data, bpi_cmd_data;
  logic [1:0]  bpi_op;
  logic [22:0] bpi_addr;
  logic        bpi_busy = 1'b0;
  logic        bpi_load = 1'b0;
  logic [15:0] bpi_din = 16'h0;

  always #5 clk = ~clk;

  bpi_cmd_sequencer #(.POLL_GAP(POLL_GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_start(start), .i_cmd(cmd), .i_addr_in(addr_in),
    .i_wdata(wdata), .o_seq_busy(seq_busy), .o_done(done), .o_err(err), .o_status(status),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_bpi_op(bpi_op), .o_bpi_addr(bpi_addr),
    .o_bpi_cmd_data(bpi_cmd_data), .o_bpi_execute(bpi_execute), .o_bpi_active(bpi_active),
    .i_bpi_busy(bpi_busy), .i_bpi_load_data(bpi_load), .i_bpi_data_in(bpi_din)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- flash model + bus scoreboard ----------------
  typedef struct packed { logic [1:0] op; logic [22:0] addr; logic [15:0] data; } bus_t;
  bus_t       exp_q[$];
  bus_t       got_bus, want_bus;
  logic [7:0] sr_q[$];
  logic [7:0] sr_final = 8'h00;
  logic [15:0] arr_val = 16'h0;
  bit         drop_load = 0;
  bit         status_mode = 0;
  bit         rd_cyc = 0;
  int         phase = 0;
  int         n_exec = 0;
  int         cyc = 0;
  int         poll_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_b) begin
      phase = 0; bpi_busy = 0; bpi_load = 0;
    end else if (phase == 1) begin
      bpi_busy = 1; phase = 2;
    end else if (phase == 2) begin
      if (rd_cyc && !drop_load) begin
        bpi_load = 1;
        if (status_mode) bpi_din = {8'h00, (sr_q.size() > 0) ? sr_q.pop_front() : sr_final};
        else             bpi_din = arr_val;
      end
      phase = 3;
    end else if (phase == 3) begin
      bpi_load = 0; bpi_busy = 0; phase = 0;
    end
    if (rst_b && bpi_execute) begin
      got_bus = {bpi_op, bpi_addr, bpi_cmd_data};
      n_exec++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_unexpected: got=%0h expected=none", got_bus);
      end else begin
        want_bus = exp_q.pop_front();
        chk("bus_cycle", got_bus, want_bus);
      end
      if (bpi_op == 2'b01) status_mode = (bpi_cmd_data != 16'h00FF);
      rd_cyc = (bpi_op == 2'b10);
      if (rd_cyc && status_mode) poll_cyc.push_back(cyc);
      phase = 1;
    end
  end

  task automatic push_w(input logic [22:0] a, input logic [15:0] d);
    exp_q.push_back({2'b01, a, d});
  endtask
  task automatic push_r(input logic [22:0] a);
    exp_q.push_back({2'b10, a, 16'h0000});
  endtask

  task automatic push_exp(input logic [2:0] c, input logic [22:0] a, input logic [15:0] wd, input int npoll);
    case (c)
      3'd1: begin push_w(a, 16'h00FF); push_r(a); end
      3'd2: begin push_w(a, 16'h0070); push_r(a); end
      3'd3: begin push_w(a, 16'h0040); push_w(a, wd); end
      3'd4: begin push_w(a, 16'h0020); push_w(a, 16'h00D0); end
      3'd5: begin push_w(a, 16'h0060); push_w(a, 16'h00D0); end
      3'd6: push_w(a, 16'h0050);
      default: ;
    endcase
    for (int i = 0; i < npoll; i++) push_r(a);
  endtask

  task automatic wait_done(input int mid_at, output bit gd, output bit rv, output int cy);
    gd = 0; rv = 0; cy = 0;
    while (!gd && cy < 3000) begin
      if (rd_valid) rv = 1;
      if (done) gd = 1;
      else begin
        start = (cy == mid_at);
        @(negedge clk);
        cy++;
      end
    end
    start = 0;
  endtask

  task automatic run_req(input logic [2:0] c, input logic [22:0] a, input logic [15:0] wd,
                         input int mid_at, output bit gd, output bit rv, output int cy);
    @(negedge clk);
    start = 1; cmd = c; addr_in = a; wdata = wd;
    @(negedge clk);
    start = 0;
    wait_done(mid_at, gd, rv, cy);
  endtask

  typedef struct {
    logic [2:0]  cmd;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] arr;
    int          n_zero;
    logic [7:0]  sr;
    logic [7:0]  exp_status;
    logic        exp_err;
    logic [15:0] exp_rd;
    logic        exp_rdv;
    int          exp_exec;
  } vec_t;

  vec_t vecs[10];
  bit   gd, rv;
  int   cy, e0, cnt;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, {seq_busy, done, err, rd_valid, bpi_execute, bpi_active}, 6'b0);
    chk({tag, "_status"}, status, 8'h00);
    chk({tag, "_rd_data"}, rd_data, 16'h0000);
    chk({tag, "_bus"}, {bpi_op, bpi_addr, bpi_cmd_data}, 41'd0);
  endtask

  initial begin
    vecs[0] = '{3'd1, 23'h12345,  16'h0000, 16'hBEEF, 0, 8'h00, 8'h80, 1'b0, 16'hBEEF, 1'b1, 2};
    vecs[1] = '{3'd3, 23'h00100,  16'hA5A5, 16'h0000, 3, 8'h80, 8'h80, 1'b0, 16'hBEEF, 1'b0, 6};
    vecs[2] = '{3'd4, 23'h40000,  16'h0000, 16'h0000, 0, 8'hA0, 8'hA0, 1'b1, 16'hBEEF, 1'b0, 3};
    vecs[3] = '{3'd2, 23'h00000,  16'h0000, 16'h0000, 0, 8'h82, 8'h82, 1'b1, 16'hBEEF, 1'b0, 2};
    vecs[4] = '{3'd5, 23'h40000,  16'h0000, 16'h0000, 0, 8'h00, 8'h82, 1'b0, 16'hBEEF, 1'b0, 2};
    vecs[5] = '{3'd6, 23'h7FFFFF, 16'h0000, 16'h0000, 0, 8'h00, 8'h82, 1'b0, 16'hBEEF, 1'b0, 1};
    vecs[6] = '{3'd0, 23'h00001,  16'h0000, 16'h0000, 0, 8'h00, 8'h82, 1'b0, 16'hBEEF, 1'b0, 0};
    vecs[7] = '{3'd7, 23'h00002,  16'h0000, 16'h0000, 0, 8'h00, 8'h82, 1'b0, 16'hBEEF, 1'b0, 0};
    vecs[8] = '{3'd3, 23'h00200,  16'h1234, 16'h0000, 1, 8'h88, 8'h88, 1'b1, 16'hBEEF, 1'b0, 4};
    vecs[9] = '{3'd1, 23'h7FFFFF, 16'h0000, 16'h0001, 0, 8'h00, 8'h88, 1'b0, 16'h0001, 1'b1, 2};

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_b = 1;
    @(negedge clk);

    // nop: DONE next cycle, START held into the DONE cycle is ignored
    e0 = n_exec;
    start = 1; cmd = 3'd0;
    @(negedge clk);
    chk("nop_done", {done, err, seq_busy}, 3'b100);
    @(negedge clk);
    start = 0;
    chk("nop_start_in_done_ignored", {done, seq_busy}, 2'b00);
    chk("nop_no_exec", n_exec - e0, 0);

    // read status: first EXECUTE is the cycle right after acceptance
    sr_q.delete(); sr_final = 8'h80;
    push_exp(3'd2, 23'h00555, 16'h0, 0);
    @(negedge clk);
    start = 1; cmd = 3'd2; addr_in = 23'h00555;
    @(negedge clk);
    start = 0;
    chk("first_exec", {bpi_execute, seq_busy, bpi_active}, 3'b111);
    chk("first_bus", {bpi_op, bpi_addr, bpi_cmd_data}, {2'b01, 23'h00555, 16'h0070});
    @(negedge clk);
    chk("exec_one_cycle", bpi_execute, 1'b0);
    wait_done(-1, gd, rv, cy);
    chk("rdstat_done", gd, 1'b1);
    chk("rdstat_result", {status, err}, {8'h80, 1'b0});

    // table of requests
    for (int i = 0; i < 10; i++) begin
      sr_q.delete();
      for (int k = 0; k < vecs[i].n_zero; k++) sr_q.push_back(8'h00);
      sr_final = vecs[i].sr;
      arr_val  = vecs[i].arr;
      poll_cyc.delete();
      e0 = n_exec;
      push_exp(vecs[i].cmd, vecs[i].addr, vecs[i].wdata,
               ((vecs[i].cmd == 3'd3) || (vecs[i].cmd == 3'd4)) ? vecs[i].n_zero + 1 : 0);
      run_req(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, -1, gd, rv, cy);
      chk($sformatf("v%0d_done", i), gd, 1'b1);
      chk($sformatf("v%0d_err", i), err, vecs[i].exp_err);
      chk($sformatf("v%0d_status", i), status, vecs[i].exp_status);
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("v%0d_rd_valid", i), rv, vecs[i].exp_rdv);
      chk($sformatf("v%0d_seq_busy", i), seq_busy, 1'b0);
      for (int k = 1; k < poll_cyc.size(); k++)
        chk($sformatf("v%0d_poll_gap", i), (poll_cyc[k] - poll_cyc[k-1]) >= (POLL_GAP + 1), 1'b1);
      @(negedge clk);
      chk($sformatf("v%0d_exec_count", i), n_exec - e0, vecs[i].exp_exec);
      chk($sformatf("v%0d_idle_op", i), {bpi_op, bpi_active}, 3'b000);
    end

    // START pulsed mid-erase adds no bus cycles
    sr_q.delete(); sr_q.push_back(8'h00); sr_q.push_back(8'h00); sr_final = 8'h80;
    e0 = n_exec;
    push_exp(3'd4, 23'h20000, 16'h0, 3);
    run_req(3'd4, 23'h20000, 16'h0, 5, gd, rv, cy);
    chk("midstart_done", {gd, err, status}, {1'b1, 1'b0, 8'h80});
    @(negedge clk);
    chk("midstart_exec_count", n_exec - e0, 5);
    chk("midstart_idle", seq_busy, 1'b0);

    // reset during the second poll GAP
    sr_q.delete();
    for (int k = 0; k < 6; k++) sr_q.push_back(8'h00);
    sr_final = 8'h80;
    poll_cyc.delete();
    push_exp(3'd3, 23'h00300, 16'h5555, 7);
    @(negedge clk);
    start = 1; cmd = 3'd3; addr_in = 23'h00300; wdata = 16'h5555;
    @(negedge clk);
    start = 0;
    cnt = 0;
    while (poll_cyc.size() < 1 && cnt < 500) begin @(negedge clk); cnt++; end
    chk("rst_first_poll_seen", poll_cyc.size(), 1);
    repeat (4) @(negedge clk);
    rst_b = 0;
    @(negedge clk);
    rst_b = 1;
    exp_q.delete(); sr_q.delete();
    check_reset_outputs("midreset");
    e0 = n_exec;
    repeat (12) @(negedge clk);
    chk("midreset_no_resume", n_exec - e0, 0);
    sr_final = 8'h84;
    push_exp(3'd2, 23'h00010, 16'h0, 0);
    run_req(3'd2, 23'h00010, 16'h0, -1, gd, rv, cy);
    chk("post_reset_rdstat", {gd, err, status}, {1'b1, 1'b0, 8'h84});

    // lost load strobe on read word and read status
    arr_val = 16'h5A5A;
    push_exp(3'd1, 23'h00042, 16'h0, 0);
    run_req(3'd1, 23'h00042, 16'h0, -1, gd, rv, cy);
    chk("read_ok", {gd, err, rv, rd_data}, {3'b101, 16'h5A5A});
    drop_load = 1; arr_val = 16'h1111;
    push_exp(3'd1, 23'h00043, 16'h0, 0);
    run_req(3'd1, 23'h00043, 16'h0, -1, gd, rv, cy);
    chk("lost_load_read", {gd, err, rv, rd_data}, {3'b111, 16'h5A5A});
    sr_final = 8'h80;
    push_exp(3'd2, 23'h00044, 16'h0, 0);
    run_req(3'd2, 23'h00044, 16'h0, -1, gd, rv, cy);
    chk("lost_load_status", {gd, err, status}, {1'b1, 1'b1, 8'h84});
    drop_load = 0;

`ifdef BPI_SEQ_TIMEOUT_EN
    sr_q.delete(); sr_final = 8'h00;
    push_exp(3'd3, 23'h00400, 16'h7777, 60);
    run_req(3'd3, 23'h00400, 16'h7777, -1, gd, rv, cy);
    chk("timeout_done", {gd, err, status}, {1'b1, 1'b1, 8'h00});
    chk("timeout_bound", cy <= TMO + 12, 1'b1);
    chk("timeout_op", bpi_op, 2'b00);
    repeat (8) @(negedge clk);
    exp_q.delete();
    chk("timeout_idle_op", bpi_op, 2'b00);
`endif

    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
